// File: rtl/rr_arb_mux_pkg.sv
// rtl/rr_arb_mux_pkg.sv - shared constants and types for the round-robin 4:1 arbiter mux
package rr_arb_mux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] ch_idx_t;

  typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational rotate-priority picker, first request at or after ptr wins
module rr_pick_4
  import rr_arb_mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         ptr,
  output logic            gnt_vld,
  output ch_idx_t         gnt_idx
);

  always_comb begin
    ch_idx_t idx;
    idx     = ptr;
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    // Scan farthest offset first so the closest request to ptr is the last to overwrite.
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = ptr + ch_idx_t'(k);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// rtl/rr_arb_mux_4_1.sv - round-robin arbiter feeding a registered valid/ready 4:1 mux stage
// Optional per-channel saturating grant counters on grant_cnt when RR_ARB_MUX_STATS_EN is defined.
module rr_arb_mux_4_1
  import rr_arb_mux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_valid,
  input  logic [W-1:0]    d0,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  input  logic [W-1:0]    d3,
  output logic [N_CH-1:0] in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output ch_idx_t         out_sel,
  input  logic            out_ready
`ifdef RR_ARB_MUX_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0] grant_cnt
`endif
);

  out_state_t   state;
  out_state_t   state_nxt;
  ch_idx_t      ptr;
  ch_idx_t      gnt_idx;
  logic         gnt_vld;
  logic         load;
  logic         grant;
  logic [W-1:0] gnt_data;

  rr_pick_4 u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign load      = (state == EMPTY) | out_ready;
  // rst_n gates the grant so nothing is accepted while reset is held.
  assign grant     = gnt_vld & load & rst_n;
  assign out_valid = (state == FULL);

  always_comb begin
    gnt_data = d0;
    case (gnt_idx)
      2'd0:    gnt_data = d0;
      2'd1:    gnt_data = d1;
      2'd2:    gnt_data = d2;
      default: gnt_data = d3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    if (grant) in_ready[gnt_idx] = 1'b1;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (out_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        out_data <= gnt_data;
        out_sel  <= gnt_idx;
        ptr      <= gnt_idx + ch_idx_t'(1);
      end
    end
  end

`ifdef RR_ARB_MUX_STATS_EN
  logic [N_CH-1:0][CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (grant && gnt_idx == ch_idx_t'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb/tb_rr_arb_mux_4_1.sv - table-driven scoreboard bench for rr_arb_mux_4_1 (RR_ARB_MUX_STATS_EN optional)
module tb_rr_arb_mux_4_1;
  localparam int W = 4;

  typedef struct {
    logic [3:0] iv;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic [1:0] exp_s;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } item_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] dv [4];
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;
`ifdef RR_ARB_MUX_STATS_EN
  logic [31:0]  grant_cnt;
`endif

  int    errors = 0;
  int    checks = 0;
  item_t sbq[$];
  vec_t  tbl[$];

  assign d0 = dv[0];
  assign d1 = dv[1];
  assign d2 = dv[2];
  assign d3 = dv[3];

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_ARB_MUX_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] iv, input logic rdy,
                              input logic [3:0] er, input logic [1:0] es);
    vec_t v;
    v.iv      = iv;
    v.rdy     = rdy;
    v.exp_rdy = er;
    v.exp_s   = es;
    return v;
  endfunction

  // One cycle: drive, check combinational accept and the held item, then update the scoreboard.
  task automatic cyc(input vec_t v);
    item_t it;
    @(negedge clk);
    in_valid  = v.iv;
    out_ready = v.rdy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(v.exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(sbq[0].data));
      chk("out_sel", 32'(out_sel), 32'(sbq[0].sel));
    end
    @(posedge clk);
    if (sbq.size() != 0 && v.rdy) void'(sbq.pop_front());
    if (v.exp_rdy != 4'b0000) begin
      it.data = dv[v.exp_s];
      it.sel  = v.exp_s;
      sbq.push_back(it);
    end
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    dv[0] = 4'ha; dv[1] = 4'hb; dv[2] = 4'hc; dv[3] = 4'hd;

    rst_cyc();
    rst_cyc();
    sbq.delete();
    #1 rst_n = 1'b1;

    tbl.push_back(mk(4'b0100, 1'b1, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b1000, 1'b1, 4'b1000, 2'd3));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0001, 2'd0));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0010, 2'd1));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b1000, 2'd3));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0001, 2'd0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b1111, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0010, 2'd1));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0100, 1'b1, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b1000, 1'b1, 4'b1000, 2'd3));
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // Wrap after channel 3 and bit-exact passthrough of an unknown word.
    #2;
    dv[0] = 4'h7;
    dv[3] = 'x;
    cyc(mk(4'b1001, 1'b1, 4'b0001, 2'd0));
    cyc(mk(4'b1001, 1'b1, 4'b1000, 2'd3));
    cyc(mk(4'b0000, 1'b1, 4'b0000, 2'd0));
    cyc(mk(4'b0000, 1'b1, 4'b0000, 2'd0));
    #2;
    dv[0] = 4'ha;
    dv[3] = 4'hd;

    // Reset while FULL with ptr=2; scanning must restart at channel 0.
    cyc(mk(4'b0010, 1'b1, 4'b0010, 2'd1));
    rst_cyc();
    rst_cyc();
    sbq.delete();
    #1 rst_n = 1'b1;
    cyc(mk(4'b1111, 1'b1, 4'b0001, 2'd0));
    cyc(mk(4'b0000, 1'b1, 4'b0000, 2'd0));

`ifdef RR_ARB_MUX_STATS_EN
    #1;
    chk("grant_cnt_one", grant_cnt, 32'h0000_0001);
    for (int i = 0; i < 300; i++) cyc(mk(4'b0001, 1'b1, 4'b0001, 2'd0));
    #1;
    chk("grant_cnt_sat", grant_cnt, 32'h0000_00ff);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
